stream_pattern_gen: RTL and testbench
=====================================

STREAM_PATTERN_GEN -- requirements
Module: stream_pattern_gen

Interface
REQ-001 SHALL have parameter C_AXIS_BYTEWIDTH, default 4: bytes per beat, range 1..8.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-003 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1: begin a run; sampled only in IDLE.
REQ-005 SHALL have port stop, input, 1: request early termination at the next packet boundary.
REQ-006 SHALL have port pkt_len, input, 16: beats per packet.
REQ-007 SHALL have port pkt_count, input, 16: packets per run.
REQ-008 SHALL have port gap_cycles, input, 8: idle cycles inserted between packets.
REQ-009 SHALL have port seed, input, 32: first data word of the run.
REQ-010 SHALL have ports output_m_axis_tvalid (out, 1), output_m_axis_tdata (out, C_AXIS_BYTEWIDTH*8), output_m_axis_tstrb (out, C_AXIS_BYTEWIDTH), output_m_axis_tlast (out, 1), output_m_axis_tready (in, 1): AXI-Stream master.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at end of run.
REQ-013 SHALL have ports byte_count and tlast_count, output, 32 each: accepted bytes and accepted tlast beats of the current run.

Function
REQ-014 SHALL implement states IDLE, SEND, GAP, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-015 In IDLE, start=1 SHALL latch pkt_len, pkt_count, gap_cycles, seed, clear both counters, and enter SEND the next cycle; if latched pkt_len=0 or pkt_count=0, SHALL enter DONE instead with no beats.
REQ-016 A beat SHALL be accepted on a cycle with tvalid=1 and tready=1.
REQ-017 tvalid SHALL be 1 in SEND only; once asserted, tvalid, tdata and tlast SHALL hold stable until the beat is accepted.
REQ-018 tdata SHALL equal a 32-bit word counter, initialised to seed, incremented by 1 (mod 2^32) per accepted beat; zero-extended when wider than 32 bits, truncated when narrower.
REQ-019 tstrb SHALL be all ones on every beat.
REQ-020 tlast SHALL be 1 on beat index pkt_len-1 of each packet; pkt_len=1 sets tlast on every beat.
REQ-021 On acceptance of a tlast beat: if the last packet or stop was seen during the packet, SHALL go to DONE; else if gap_cycles>0, SHALL go to GAP; else SHALL stay in SEND with tvalid continuously high (back-to-back).
REQ-022 GAP SHALL last exactly gap_cycles cycles with tvalid=0, then return to SEND; stop=1 during GAP SHALL go to DONE the next cycle.
REQ-023 stop SHALL be latched; it never truncates a packet mid-way.
REQ-024 byte_count SHALL add C_AXIS_BYTEWIDTH per accepted beat; tlast_count SHALL add 1 per accepted tlast beat; both wrap mod 2^32 and hold their value after DONE until the next start.
REQ-025 done SHALL be 1 exactly in the DONE cycle; busy=1 in SEND, GAP, DONE.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 Input changes to pkt_len/pkt_count/gap_cycles/seed while busy SHALL have no effect on the run.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE, tvalid=0, tlast=0, tdata=0, tstrb=all ones, busy=0, done=0, byte_count=0, tlast_count=0, latched stop=0, including mid-packet.
REQ-029 After resetn rises, no beat SHALL issue until a new start.

Verification
REQ-030 pkt_len=4, pkt_count=2, gap=0, seed=0x10, tready=1 -> 8 consecutive beats 0x10..0x17, tlast on 0x13 and 0x17, byte_count=32, tlast_count=2, done pulse once.
REQ-031 pkt_len=3, pkt_count=2, gap=2, tready=1 -> exactly 2 tvalid=0 cycles between beats 3 and 4.
REQ-032 pkt_len=4, pkt_count=1, tready toggling 1,0,0,1,... -> tdata/tlast stable while stalled, 4 beats total, byte_count=16.
REQ-033 pkt_len=5, pkt_count=10, stop pulsed during beat 2 of packet 1 -> packet 1 completes (5 beats), done, tlast_count=1.
REQ-034 pkt_len=0, start -> done next-but-one cycle, no tvalid, counters 0; separately resetn low during beat 3 -> tvalid=0 same cycle, counters 0.
REQ-035 seed=0xFFFFFFFF, pkt_len=2 -> tdata 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/stream_pattern_gen.sv
// AXI-Stream test pattern generator: emits runs of fixed-length packets carrying an
// incrementing 32-bit word, with optional inter-packet gaps and early stop.
`timescale 1ns/1ps
module stream_pattern_gen #(
  parameter int C_AXIS_BYTEWIDTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          stop,
  input  logic [15:0]                   pkt_len,
  input  logic [15:0]                   pkt_count,
  input  logic [7:0]                    gap_cycles,
  input  logic [31:0]                   seed,
  output logic                          output_m_axis_tvalid,
  output logic [C_AXIS_BYTEWIDTH*8-1:0] output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tstrb,
  output logic                          output_m_axis_tlast,
  input  logic                          output_m_axis_tready,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   byte_count,
  output logic [31:0]                   tlast_count
);

  localparam int DATA_W = C_AXIS_BYTEWIDTH * 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] len_q, cnt_q, beat_q, pkt_q;
  logic [7:0]  gap_q, gap_cnt_q;
  logic [31:0] word_q;
  logic        stop_q;
  logic        accept, last_beat, last_pkt, end_run;

  assign accept    = (state == SEND) && output_m_axis_tready;
  assign last_beat = (beat_q == len_q - 16'd1);
  assign last_pkt  = (pkt_q == cnt_q - 16'd1);
  // A stop arriving on the tlast handshake itself still ends the run at this boundary.
  assign end_run   = last_pkt || stop_q || stop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (pkt_len == 16'd0 || pkt_count == 16'd0) ? DONE : SEND;
      SEND: begin
        if (accept && last_beat) begin
          if (end_run)              state_nxt = DONE;
          else if (gap_q != 8'd0)   state_nxt = GAP;
        end
      end
      GAP: begin
        if (stop)                   state_nxt = DONE;
        else if (gap_cnt_q <= 8'd1) state_nxt = SEND;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      word_q      <= '0;
      beat_q      <= '0;
      pkt_q       <= '0;
      gap_cnt_q   <= '0;
      stop_q      <= 1'b0;
      byte_count  <= '0;
      tlast_count <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        len_q       <= pkt_len;
        cnt_q       <= pkt_count;
        gap_q       <= gap_cycles;
        word_q      <= seed;
        beat_q      <= '0;
        pkt_q       <= '0;
        stop_q      <= 1'b0;
        byte_count  <= '0;
        tlast_count <= '0;
      end
    end else begin
      if (stop && (state == SEND || state == GAP)) stop_q <= 1'b1;
      if (accept) begin
        word_q     <= word_q + 32'd1;
        byte_count <= byte_count + 32'(C_AXIS_BYTEWIDTH);
        if (last_beat) begin
          beat_q      <= '0;
          pkt_q       <= pkt_q + 16'd1;
          tlast_count <= tlast_count + 32'd1;
          gap_cnt_q   <= gap_q;
        end else begin
          beat_q <= beat_q + 16'd1;
        end
      end
      if (state == GAP) gap_cnt_q <= gap_cnt_q - 8'd1;
    end
  end

  // Outputs decode straight from registered state, so reset clears them immediately.
  assign output_m_axis_tvalid = (state == SEND);
  assign output_m_axis_tlast  = (state == SEND) && last_beat;
  assign output_m_axis_tdata  = DATA_W'(word_q);
  assign output_m_axis_tstrb  = '1;
  assign busy                 = (state != IDLE);
  assign done                 = (state == DONE);

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Self-checking bench for stream_pattern_gen: directed scenarios plus randomized runs
// scored against a packet-level model of the expected beat stream.
`timescale 1ns/1ps
module tb_stream_pattern_gen;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] pkt_count = '0;
  logic [7:0]  gap_cycles = '0;
  logic [31:0] seed = '0;
  logic        tvalid, tlast, busy, done;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tready = 1'b0;
  logic [31:0] byte_count, tlast_count;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] cap_data[$];
  bit          cap_last[$];
  int          cap_cyc[$];
  int          done_cnt, done_cyc, stall_viol, low_cyc, post_valid;
  logic [31:0] exp_data[$];
  bit          exp_last[$];

  stream_pattern_gen #(.C_AXIS_BYTEWIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .gap_cycles(gap_cycles), .seed(seed),
    .output_m_axis_tvalid(tvalid), .output_m_axis_tdata(tdata), .output_m_axis_tstrb(tstrb),
    .output_m_axis_tlast(tlast), .output_m_axis_tready(tready),
    .busy(busy), .done(done), .byte_count(byte_count), .tlast_count(tlast_count)
  );

  always #5 clk = ~clk;

  // Expected stream: npk whole packets of len beats, word = seed + beat number.
  function automatic void build_model(input int len, input int npk, input logic [31:0] sd);
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < len * npk; i++) begin
      exp_data.push_back(sd + 32'(i));
      exp_last.push_back((i % len) == len - 1);
    end
  endfunction

  // Starts a run and records what the stream did; rmode 0=ready, 1=1,0,0 pattern, 2=random.
  task automatic run_capture(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap,
                             input logic [31:0] sd, input int rmode, input int stop_cyc,
                             input bit scramble);
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    int          after;
    cap_data.delete(); cap_last.delete(); cap_cyc.delete();
    done_cnt = 0; done_cyc = -1; stall_viol = 0; low_cyc = 0; post_valid = 0;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0; after = -1;
    @(negedge clk);
    pkt_len = len; pkt_count = cnt; gap_cycles = gap; seed = sd; start = 1'b1; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      case (rmode)
        0:       tready = 1'b1;
        1:       tready = (c % 3 == 0);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      stop = (c == stop_cyc);
      if (scramble && done_cnt == 0) begin
        pkt_len = 16'($urandom); pkt_count = 16'($urandom);
        gap_cycles = 8'($urandom); seed = $urandom;
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      #1;
      if (prev_stall && (!tvalid || tdata !== prev_d || tlast !== prev_l)) stall_viol++;
      if (tvalid && tready) begin
        cap_data.push_back(tdata); cap_last.push_back(tlast); cap_cyc.push_back(c);
      end
      if (busy && !tvalid && !done) low_cyc++;
      if (done_cnt > 0 && tvalid) post_valid++;
      prev_stall = tvalid && !tready; prev_d = tdata; prev_l = tlast;
      if (done) begin done_cnt++; done_cyc = c; end
      if (done_cnt > 0) begin
        after++;
        if (after == 3) break;
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; tready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({tvalid, tlast, busy, done} !== 4'b0000 || tdata !== 32'd0 || tstrb !== 4'hF) begin
      errors++;
      $display("FAIL reset_outputs: vld/last/busy/done=%b tdata=%h tstrb=%h, expected 0000 0 F",
               {tvalid, tlast, busy, done}, tdata, tstrb);
    end
    vectors++;
    if (byte_count !== 32'd0 || tlast_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", byte_count, tlast_count);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back;
    run_capture(16'd4, 16'd2, 8'd0, 32'h10, 0, -1, 1'b0);
    build_model(4, 2, 32'h10);
    vectors++;
    if (cap_data.size() != 8) begin
      errors++; $display("FAIL b2b_beats: got %0d expected 8", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h/%0b expected %h/%0b", i, cap_data[i], cap_last[i],
                 exp_data[i], exp_last[i]);
      end
    end
    vectors++;
    if (cap_data.size() == 8 && cap_cyc[7] - cap_cyc[0] != 7) begin
      errors++; $display("FAIL b2b_consecutive: span %0d expected 7", cap_cyc[7] - cap_cyc[0]);
    end
    vectors++;
    if (byte_count !== 32'd32 || tlast_count !== 32'd2) begin
      errors++; $display("FAIL b2b_counters: got %0d/%0d expected 32/2", byte_count, tlast_count);
    end
    vectors++;
    if (done_cnt != 1 || low_cyc != 0 || post_valid != 0) begin
      errors++;
      $display("FAIL b2b_done: done=%0d low=%0d post=%0d expected 1/0/0", done_cnt, low_cyc, post_valid);
    end
  endtask

  task automatic test_gap;
    logic [31:0] sd;
    sd = $urandom;
    run_capture(16'd3, 16'd2, 8'd2, sd, 0, -1, 1'b0);
    build_model(3, 2, sd);
    vectors++;
    if (cap_data.size() != 6) begin
      errors++; $display("FAIL gap_beats: got %0d expected 6", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL gap_beat%0d: got %h/%0b expected %h/%0b", i, cap_data[i], cap_last[i],
                 exp_data[i], exp_last[i]);
      end
    end
    vectors++;
    if (cap_data.size() == 6 && (cap_cyc[3] - cap_cyc[2] != 3 || low_cyc != 2)) begin
      errors++;
      $display("FAIL gap_idle: spacing %0d idle %0d expected 3/2", cap_cyc[3] - cap_cyc[2], low_cyc);
    end
  endtask

  task automatic test_stall;
    logic [31:0] sd;
    sd = $urandom;
    run_capture(16'd4, 16'd1, 8'd0, sd, 1, -1, 1'b0);
    build_model(4, 1, sd);
    vectors++;
    if (cap_data.size() != 4 || stall_viol != 0) begin
      errors++;
      $display("FAIL stall_hold: beats %0d unstable %0d expected 4/0", cap_data.size(), stall_viol);
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h/%0b expected %h/%0b", i, cap_data[i], cap_last[i],
                 exp_data[i], exp_last[i]);
      end
    end
    vectors++;
    if (byte_count !== 32'd16) begin
      errors++; $display("FAIL stall_bytes: got %0d expected 16", byte_count);
    end
  endtask

  task automatic test_stop;
    logic [31:0] sd;
    sd = $urandom;
    run_capture(16'd5, 16'd10, 8'd0, sd, 0, 2, 1'b0);
    build_model(5, 1, sd);
    vectors++;
    if (cap_data.size() != 5 || tlast_count !== 32'd1 || done_cnt != 1) begin
      errors++;
      $display("FAIL stop_packet: beats %0d tlasts %0d done %0d expected 5/1/1",
               cap_data.size(), tlast_count, done_cnt);
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL stop_beat%0d: got %h/%0b expected %h/%0b", i, cap_data[i], cap_last[i],
                 exp_data[i], exp_last[i]);
      end
    end
    run_capture(16'd2, 16'd5, 8'd4, $urandom, 0, 3, 1'b0);
    vectors++;
    if (cap_data.size() != 2 || low_cyc != 2 || tlast_count !== 32'd1 || done_cnt != 1) begin
      errors++;
      $display("FAIL stop_in_gap: beats %0d idle %0d tlasts %0d done %0d expected 2/2/1/1",
               cap_data.size(), low_cyc, tlast_count, done_cnt);
    end
  endtask

  task automatic test_zero_len;
    run_capture(16'd0, 16'd3, 8'd1, $urandom, 0, -1, 1'b0);
    vectors++;
    if (cap_data.size() != 0 || done_cnt != 1 || done_cyc > 1 || post_valid != 0) begin
      errors++;
      $display("FAIL zero_len: beats %0d done %0d at %0d expected 0/1/<=1",
               cap_data.size(), done_cnt, done_cyc);
    end
    vectors++;
    if (byte_count !== 32'd0 || tlast_count !== 32'd0) begin
      errors++; $display("FAIL zero_len_counters: got %0d/%0d expected 0/0", byte_count, tlast_count);
    end
    run_capture(16'd4, 16'd0, 8'd0, $urandom, 0, -1, 1'b0);
    vectors++;
    if (cap_data.size() != 0 || done_cnt != 1 || done_cyc > 1) begin
      errors++;
      $display("FAIL zero_count: beats %0d done %0d at %0d expected 0/1/<=1",
               cap_data.size(), done_cnt, done_cyc);
    end
  endtask

  task automatic test_wrap;
    run_capture(16'd2, 16'd1, 8'd0, 32'hFFFF_FFFF, 0, -1, 1'b0);
    vectors++;
    if (cap_data.size() != 2) begin
      errors++; $display("FAIL wrap_beats: got %0d expected 2", cap_data.size());
    end else if (cap_data[0] !== 32'hFFFF_FFFF || cap_data[1] !== 32'h0 || cap_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_data: got %h %h last %0b expected ffffffff 00000000 1",
               cap_data[0], cap_data[1], cap_last[1]);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    pkt_len = 16'd8; pkt_count = 16'd1; gap_cycles = 8'd0; seed = $urandom;
    start = 1'b1; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    vectors++;
    if (tvalid !== 1'b1 || byte_count !== 32'd12) begin
      errors++; $display("FAIL midrun_pre: vld %b bytes %0d expected 1/12", tvalid, byte_count);
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'd0 || busy !== 1'b0 ||
        byte_count !== 32'd0 || tlast_count !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset: vld %b last %b data %h busy %b bytes %0d tlasts %0d expected all 0",
               tvalid, tlast, tdata, busy, byte_count, tlast_count);
    end
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (tvalid || busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++; $display("FAIL post_reset_idle: %0d active cycles expected 0", bad);
    end
    tready = 1'b0;
  endtask

  task automatic test_random;
    int          len, cnt, gap;
    logic [31:0] sd;
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 6);
      cnt = $urandom_range(1, 4);
      gap = $urandom_range(0, 3);
      sd  = $urandom;
      run_capture(16'(len), 16'(cnt), 8'(gap), sd, 2, -1, 1'b1);
      build_model(len, cnt, sd);
      vectors++;
      if (cap_data.size() != exp_data.size()) begin
        errors++;
        $display("FAIL rand%0d_beats: got %0d expected %0d", r, cap_data.size(), exp_data.size());
      end
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
        vectors++;
        if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: got %h/%0b expected %h/%0b", r, i, cap_data[i],
                   cap_last[i], exp_data[i], exp_last[i]);
        end
      end
      vectors++;
      if (byte_count !== 32'(4 * len * cnt) || tlast_count !== 32'(cnt)) begin
        errors++;
        $display("FAIL rand%0d_counters: got %0d/%0d expected %0d/%0d", r, byte_count,
                 tlast_count, 4 * len * cnt, cnt);
      end
      vectors++;
      if (low_cyc != (cnt - 1) * gap || stall_viol != 0 || done_cnt != 1 || post_valid != 0) begin
        errors++;
        $display("FAIL rand%0d_timing: idle %0d unstable %0d done %0d post %0d expected %0d/0/1/0",
                 r, low_cyc, stall_viol, done_cnt, post_valid, (cnt - 1) * gap);
      end
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_gap;
    test_stall;
    test_stop;
    test_zero_len;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
